// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the sequential add/subtract + BCD display path.
//   state_e    : controller states (IDLE, CALC, CONV)
//   SIGN_POS   : sign-digit code shown for a non-negative result
//   SIGN_NEG   : sign-digit code shown for a negative result
//   min_digits : smallest BCD digit count that can hold 2^(width+1)-1
// ----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2
    } state_e;

    localparam logic [3:0] SIGN_POS = 4'hE;
    localparam logic [3:0] SIGN_NEG = 4'hF;

    // Largest magnitude is 2^(width+1)-1 (a+b+cin at full scale); count how
    // many decimal digits that needs. The loop bound keeps 10^d inside 64 bits.
    function automatic int min_digits(input int width);
        longint max_val;
        longint pow10;
        int     d;
        max_val = (longint'(1) << (width + 1)) - 1;
        d       = 1;
        pow10   = 10;
        for (int i = 0; i < 17; i++) begin
            if (pow10 <= max_val) begin
                d     = d + 1;
                pow10 = pow10 * 10;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_dabble.sv
// ----------------------------------------------------------------------------
// bin2bcd_dabble
// Iterative shift-add-3 (double-dabble) binary to packed BCD datapath.
// One step per cycle while step=1; N steps convert an N-bit value.
//   clk     : clock
//   rst     : synchronous active-high reset, clears the shift register
//   load    : load {BCD=0, bin} into the shift register
//   bin     : N-bit binary value to convert
//   step    : perform one add-3/shift step
//   bcd_out : BCD field as it will be after the next step (combinational),
//             so the controller can capture the final result on the same
//             edge that performs the last step
// ----------------------------------------------------------------------------
module bin2bcd_dabble #(
    parameter int N      = 9,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [N-1:0]          bin,
    input  logic                  step,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int RW = 4 * DIGITS + N;

    logic [RW-1:0]         sr_q;
    logic [RW-1:0]         sr_d;
    logic [4*DIGITS-1:0]   adj;

    // Add 3 to every digit that is 5 or more before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = sr_q[N + 4*gi +: 4];
            assign adj[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    endgenerate

    assign sr_d    = {adj, sr_q[N-1:0]} << 1;
    assign bcd_out = sr_d[RW-1:N];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= {{(4*DIGITS){1'b0}}, bin};
        end else if (step) begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/addsub_bcd_seq.sv
// ----------------------------------------------------------------------------
// addsub_bcd_seq
// Clocked adder/subtractor producing a sign-magnitude result as packed BCD.
// Operands are captured on start (IDLE only), the arithmetic is done in one
// CALC cycle, then WIDTH+1 double-dabble steps run in CONV. Results are
// registered and updated only when done pulses.
//   clk       : clock
//   rst       : synchronous active-high reset (aborts any operation)
//   start     : request, sampled only in IDLE
//   mode      : 1 = a+b+cin, 0 = a-b-cin
//   cin       : carry-in / borrow-in
//   a, b      : WIDTH-bit unsigned operands
//   busy      : operation in flight
//   done      : one-cycle pulse, results valid from this cycle on
//   neg       : result negative
//   sign_code : SIGN_NEG when neg, SIGN_POS otherwise
//   bcd       : packed BCD magnitude, digit 0 in bits [3:0]
// ----------------------------------------------------------------------------
module addsub_bcd_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  cin,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [3:0]            sign_code,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("addsub_bcd_seq: WIDTH must be at least 2");
        end
        if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
            $error("addsub_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_e                state_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  cin_q;
    logic                  mode_q;
    logic [CW-1:0]         cnt_q;
    logic                  neg_pend_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  neg_q;
    logic [3:0]            sign_code_q;
    logic [4*DIGITS-1:0]   bcd_q;

    // Arithmetic on the captured operands, consumed in CALC.
    logic [N-1:0]          sum_full;
    logic signed [N:0]     diff;
    logic [N:0]            abs_diff;
    logic                  unused_abs_msb;
    logic [N-1:0]          mag_d;
    logic                  neg_d;
    logic [4*DIGITS-1:0]   dab_bcd;

    assign sum_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    // WIDTH+2 bits signed covers -(2^WIDTH) .. 2^WIDTH-1 without overflow.
    assign diff     = $signed({2'b00, a_q}) - $signed({2'b00, b_q})
                    - $signed({{(N){1'b0}}, cin_q});
    assign abs_diff = diff[N] ? (-diff) : diff;
    // |diff| <= 2^WIDTH always fits N bits; the top bit is always zero.
    assign unused_abs_msb = abs_diff[N];

    always_comb begin
        mag_d = sum_full;
        neg_d = 1'b0;
        if (!mode_q) begin
            mag_d = abs_diff[N-1:0];
            neg_d = diff[N];
        end
    end

    bin2bcd_dabble #(
        .N      (N),
        .DIGITS (DIGITS)
    ) u_dabble (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q == CALC),
        .bin     (mag_d),
        .step    (state_q == CONV),
        .bcd_out (dab_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            neg_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            neg_q       <= 1'b0;
            sign_code_q <= SIGN_POS;
            bcd_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        cin_q   <= cin;
                        mode_q  <= mode;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // The dabble register is loaded with mag_d on this edge.
                    neg_pend_q <= neg_d;
                    cnt_q      <= '0;
                    state_q    <= CONV;
                end
                CONV: begin
                    if (cnt_q == LAST_STEP) begin
                        bcd_q       <= dab_bcd;
                        neg_q       <= neg_pend_q;
                        sign_code_q <= neg_pend_q ? SIGN_NEG : SIGN_POS;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign neg       = neg_q;
    assign sign_code = sign_code_q;
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_addsub_bcd_seq.sv
module tb_addsub_bcd_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // WIDTH=8, DIGITS=3 instance
    logic        start, mode, cin;
    logic [7:0]  a, b;
    logic        busy, done, neg;
    logic [3:0]  sign_code;
    logic [11:0] bcd;

    // WIDTH=4, DIGITS=2 instance
    logic        start4, mode4, cin4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, neg4;
    logic [3:0]  sign_code4;
    logic [7:0]  bcd4;

    addsub_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .neg(neg),
        .sign_code(sign_code), .bcd(bcd)
    );

    addsub_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .cin(cin4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .neg(neg4),
        .sign_code(sign_code4), .bcd(bcd4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        mode;
        logic        cin;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] exp_bcd;
        logic        exp_neg;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: decimal digits by division.
    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d2, d1, d0};
    endfunction

    // Starts one operation on the 8-bit instance and returns the number of
    // edges after the accept edge until done is seen (-1 on timeout).
    task automatic run_op(input logic md, input logic c, input logic [7:0] aa,
                          input logic [7:0] bb, output int lat);
        mode = md; cin = c; a = aa; b = bb; start = 1'b1;
        tick();
        start = 1'b0;
        // operands scrambled after capture must not matter
        mode = ~md; cin = ~c; a = ~aa; b = ~bb;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op4(input logic md, input logic c, input logic [3:0] aa,
                           input logic [3:0] bb, output int lat);
        mode4 = md; cin4 = c; a4 = aa; b4 = bb; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done4) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int mag;
        int r;
        int k;
        logic [7:0] fa, fb;
        logic fc, fm;

        vecs[0] = '{1'b1, 1'b1, 8'd100, 8'd23,  12'h124, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'd3,   8'd5,   12'h002, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'd5,   8'd5,   12'h000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'd255, 8'd255, 12'h511, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'd0,   8'd255, 12'h256, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'd200, 8'd55,  12'h144, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'd0,   8'd0,   12'h000, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'd10,  8'd0,   12'h009, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 8'd0,   8'd0,   12'h001, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 8'd99,  8'd1,   12'h100, 1'b0};

        rst = 1'b1;
        start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        start4 = 1'b0; mode4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_neg", 32'(neg), 32'd0);
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_sign", 32'(sign_code), 32'hE);
        check("reset4_bcd", 32'(bcd4), 32'h0);
        rst = 1'b0;
        tick();

        // Table-driven single operations
        for (int v = 0; v < NV; v++) begin
            run_op(vecs[v].mode, vecs[v].cin, vecs[v].a, vecs[v].b, lat);
            $display("[TB] vec %0d mode=%0d cin=%0d a=%0d b=%0d -> lat=%0d bcd=%03h neg=%0d sign=%0h",
                     v, vecs[v].mode, vecs[v].cin, vecs[v].a, vecs[v].b, lat, bcd, neg, sign_code);
            check("vec_latency", 32'(lat), 32'd10);
            check("vec_bcd", 32'(bcd), 32'(vecs[v].exp_bcd));
            check("vec_neg", 32'(neg), 32'(vecs[v].exp_neg));
            check("vec_sign", 32'(sign_code), vecs[v].exp_neg ? 32'hF : 32'hE);
        end

        // start pulsed mid-operation must be ignored; outputs hold until done
        mode = 1'b1; cin = 1'b1; a = 8'd100; b = 8'd23; start = 1'b1;
        tick();
        ndone = 0;
        lat = -1;
        for (int i = 1; i <= 25; i++) begin
            if (i >= 4 && i <= 6) begin
                start = 1'b1; mode = 1'b0; a = 8'd1; b = 8'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                ndone++;
                lat = i;
                check("ignore_bcd", 32'(bcd), 32'h124);
            end else if (i < 10) begin
                check("ignore_busy", 32'(busy), 32'd1);
                check("ignore_hold", 32'(bcd), 32'(vecs[NV-1].exp_bcd));
            end
        end
        $display("[TB] mid-op start: dones=%0d lat=%0d bcd=%03h", ndone, lat, bcd);
        check("ignore_ndone", 32'(ndone), 32'd1);
        check("ignore_lat", 32'(lat), 32'd10);

        // Reset 4 cycles after start aborts, no done
        mode = 1'b1; cin = 1'b0; a = 8'd50; b = 8'd60; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h0);
        check("abort_neg", 32'(neg), 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        $display("[TB] abort: dones after reset=%0d", ndone);
        check("abort_nodone", 32'(ndone), 32'd0);
        run_op(1'b1, 1'b0, 8'd50, 8'd60, lat);
        $display("[TB] post-abort op: lat=%0d bcd=%03h", lat, bcd);
        check("abort_rerun_lat", 32'(lat), 32'd10);
        check("abort_rerun_bcd", 32'(bcd), 32'h110);

        // Back-to-back with start held high; operands change every cycle
        ndone = 0;
        start = 1'b1;
        for (int c = 0; c < 35; c++) begin
            a = 8'(c * 37 + 5); b = 8'(c * 11 + 200); cin = 1'(c); mode = (c % 3 != 0);
            tick();
            if (done) begin
                k = ndone;
                fa = 8'(11 * k * 37 + 5); fb = 8'(11 * k * 11 + 200);
                fc = 1'(11 * k); fm = ((11 * k) % 3 != 0);
                if (fm) r = int'(fa) + int'(fb) + int'(fc);
                else    r = int'(fa) - int'(fb) - int'(fc);
                mag = (r < 0) ? -r : r;
                $display("[TB] b2b op %0d done at edge %0d: bcd=%03h neg=%0d exp=%03h/%0d",
                         k, c, bcd, neg, to_bcd(mag), (r < 0));
                check("b2b_edge", 32'(c), 32'(11 * k + 10));
                check("b2b_bcd", 32'(bcd), 32'(to_bcd(mag)));
                check("b2b_neg", 32'(neg), 32'(r < 0));
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(ndone), 32'd3);
        repeat (15) tick();

        // WIDTH=4, DIGITS=2 instance
        run_op4(1'b1, 1'b1, 4'd15, 4'd15, lat);
        $display("[TB] w4 15+15+1: lat=%0d bcd=%02h neg=%0d", lat, bcd4, neg4);
        check("w4_add_lat", 32'(lat), 32'd6);
        check("w4_add_bcd", 32'(bcd4), 32'h31);
        check("w4_add_neg", 32'(neg4), 32'd0);
        run_op4(1'b0, 1'b1, 4'd0, 4'd15, lat);
        $display("[TB] w4 0-15-1: lat=%0d bcd=%02h neg=%0d sign=%0h", lat, bcd4, neg4, sign_code4);
        check("w4_sub_bcd", 32'(bcd4), 32'h16);
        check("w4_sub_neg", 32'(neg4), 32'd1);
        check("w4_sub_sign", 32'(sign_code4), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
